dualport_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares the 8x16 dual-port memory between requester A and requester B. It runs on one clock, with the memory's write and read clocks both tied to that clock. Each cycle it drives at most one registered write or read command onto the memory ports, and it routes read data back to the issuing requester with a tag pipeline matched to the memory read latency. It sits between the two client blocks and the memory instance.

---
 rtl/dualport_arbiter.sv | 139 +++++++++++++
 tb/tb_dualport_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dualport_arbiter.sv
// dualport_arbiter
//   Round-robin arbiter that lets requesters A and B share one 2**AW x DW
//   dual-port memory running on the same clock. At most one registered
//   write or read command reaches the memory ports each cycle. Read data is
//   steered back to the issuing requester by a tag pipeline that matches the
//   memory read latency.
//
// Ports
//   clk, clr                 single clock, synchronous active-high reset
//   req_x, wr_x, addr_x,     request from requester x (a or b); wr=1 write,
//   wdata_x                  wr=0 read
//   gnt_x                    one-cycle pulse: the request was accepted
//   rvalid_x, rdata_x        one-cycle pulse with read data for requester x
//   mem_we, mem_wr_addr,     memory write port
//   mem_data_in
//   mem_re, mem_rd_addr      memory read port
//   mem_data_out             memory read data, valid RD_LAT cycles after mem_re
//
// Handshake: a requester raises req with wr/addr/wdata and holds all of them
// stable until it sees gnt; in the cycle gnt is high it may drop req or put
// up the next request. A requester that was granted in this cycle is masked
// from arbitration, so a held req is never granted twice and a lone
// requester gets at most one access every two cycles. Read returns carry no
// backpressure: rvalid must be accepted when it fires.

module dualport_arbiter #(
  parameter int DW     = 16,
  parameter int AW     = 3,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req_a,
  input  logic          wr_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          req_b,
  input  logic          wr_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_wr_addr,
  output logic [AW-1:0] mem_rd_addr,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out
);

  // Round-robin pointer: 0 = A was granted last, 1 = B was granted last.
  logic last_gnt;

  logic          elig_a, elig_b;
  logic          win_a, win_b, win_any;
  logic          win_wr;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  // Read tag pipeline. Stage 0 is loaded from the command currently on the
  // memory ports, so the last stage lines up with valid mem_data_out.
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_id;

  // gnt_x is high in the cycle right after x was accepted; masking with it
  // keeps a still-held req from being granted a second time.
  assign elig_a = req_a & ~gnt_a;
  assign elig_b = req_b & ~gnt_b;

  always_comb begin
    win_a = 1'b0;
    win_b = 1'b0;
    if (elig_a && elig_b) begin
      if (last_gnt) win_a = 1'b1;
      else          win_b = 1'b1;
    end else if (elig_a) begin
      win_a = 1'b1;
    end else if (elig_b) begin
      win_b = 1'b1;
    end
  end

  assign win_any   = win_a | win_b;
  assign win_wr    = win_b ? wr_b    : wr_a;
  assign win_addr  = win_b ? addr_b  : addr_a;
  assign win_wdata = win_b ? wdata_b : wdata_a;

  always_ff @(posedge clk) begin
    if (clr) begin
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      rvalid_a    <= 1'b0;
      rvalid_b    <= 1'b0;
      rdata_a     <= '0;
      rdata_b     <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      mem_wr_addr <= '0;
      mem_rd_addr <= '0;
      mem_data_in <= '0;
      last_gnt    <= 1'b1;
      tag_v       <= '0;
      tag_id      <= '0;
    end else begin
      gnt_a  <= win_a;
      gnt_b  <= win_b;
      mem_we <= win_any & win_wr;
      mem_re <= win_any & ~win_wr;
      if (win_any) begin
        last_gnt <= win_b;
        // Only the port that is used moves; the other keeps its last value.
        if (win_wr) begin
          mem_wr_addr <= win_addr;
          mem_data_in <= win_wdata;
        end else begin
          mem_rd_addr <= win_addr;
        end
      end

      // While mem_re is high, gnt_b names the requester that issued it.
      tag_v[0]  <= mem_re;
      tag_id[0] <= gnt_b;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end

      rvalid_a <= tag_v[RD_LAT-1] & ~tag_id[RD_LAT-1];
      rvalid_b <= tag_v[RD_LAT-1] &  tag_id[RD_LAT-1];
      if (tag_v[RD_LAT-1] && !tag_id[RD_LAT-1]) rdata_a <= mem_data_out;
      if (tag_v[RD_LAT-1] &&  tag_id[RD_LAT-1]) rdata_b <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_dualport_arbiter.sv
// tb_dualport_arbiter
//   Drives two arbiter builds (RD_LAT=1 and RD_LAT=3) with the same request
//   stream, each attached to its own behavioural 8x16 memory. Grants and
//   memory commands are checked on the RD_LAT=1 build; read returns of both
//   builds are checked against an expected queue filled by the drivers.

module tb_dualport_arbiter;

  localparam int DW   = 16;
  localparam int AW   = 3;
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;
  localparam int EW   = 49;  // {cycle[31:0], id, data[15:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared stimulus ----------------
  logic          req_a = 1'b0, wr_a = 1'b0, req_b = 1'b0, wr_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;

  // ---------------- DUT with RD_LAT=1 ----------------
  logic          gnt_a_1, gnt_b_1, rvalid_a_1, rvalid_b_1, mem_we_1, mem_re_1;
  logic [DW-1:0] rdata_a_1, rdata_b_1, mem_data_in_1, mout1;
  logic [AW-1:0] mem_wr_addr_1, mem_rd_addr_1;

  dualport_arbiter #(.DW(DW), .AW(AW), .RD_LAT(LAT1)) dut1 (
    .clk(clk), .clr(clr),
    .req_a(req_a), .wr_a(wr_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .wr_b(wr_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a_1), .gnt_b(gnt_b_1),
    .rvalid_a(rvalid_a_1), .rvalid_b(rvalid_b_1),
    .rdata_a(rdata_a_1), .rdata_b(rdata_b_1),
    .mem_we(mem_we_1), .mem_re(mem_re_1),
    .mem_wr_addr(mem_wr_addr_1), .mem_rd_addr(mem_rd_addr_1),
    .mem_data_in(mem_data_in_1), .mem_data_out(mout1)
  );

  logic [DW-1:0] mem1 [8];
  always @(posedge clk) begin
    if (mem_we_1) mem1[mem_wr_addr_1] <= mem_data_in_1;
    if (mem_re_1) mout1 <= mem1[mem_rd_addr_1];
  end

  // ---------------- DUT with RD_LAT=3 ----------------
  logic          gnt_a_3, gnt_b_3, rvalid_a_3, rvalid_b_3, mem_we_3, mem_re_3;
  logic [DW-1:0] rdata_a_3, rdata_b_3, mem_data_in_3, mout3;
  logic [AW-1:0] mem_wr_addr_3, mem_rd_addr_3;

  dualport_arbiter #(.DW(DW), .AW(AW), .RD_LAT(LAT3)) dut3 (
    .clk(clk), .clr(clr),
    .req_a(req_a), .wr_a(wr_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .wr_b(wr_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a_3), .gnt_b(gnt_b_3),
    .rvalid_a(rvalid_a_3), .rvalid_b(rvalid_b_3),
    .rdata_a(rdata_a_3), .rdata_b(rdata_b_3),
    .mem_we(mem_we_3), .mem_re(mem_re_3),
    .mem_wr_addr(mem_wr_addr_3), .mem_rd_addr(mem_rd_addr_3),
    .mem_data_in(mem_data_in_3), .mem_data_out(mout3)
  );

  logic [DW-1:0] mem3 [8];
  logic [DW-1:0] pipe3 [3];
  always @(posedge clk) begin
    if (mem_we_3) mem3[mem_wr_addr_3] <= mem_data_in_3;
    pipe3[0] <= mem_re_3 ? mem3[mem_rd_addr_3] : pipe3[0];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mout3 = pipe3[2];

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q3[$];
  logic [DW-1:0] shadow [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic ret_mon(input bit sel, input string pref, input logic va, input logic vb,
                         input logic [DW-1:0] da, input logic [DW-1:0] db);
    logic [EW-1:0] e;
    bit have;
    e    = '0;
    have = sel ? (exp_q3.size() > 0) : (exp_q1.size() > 0);
    if (have) e = sel ? exp_q3[0] : exp_q1[0];
    if (va || vb) begin
      if (va && vb) check({pref, "_rv_both"}, 1, 0);
      if (!have) begin
        check({pref, "_rv_spurious"}, {30'd0, va, vb}, 0);
      end else begin
        if (sel) void'(exp_q3.pop_front());
        else     void'(exp_q1.pop_front());
        check({pref, "_rv_port"}, {31'd0, vb}, {31'd0, e[16]});
        check({pref, "_rv_data"}, {16'd0, va ? da : db}, {16'd0, e[15:0]});
        check({pref, "_rv_cycle"}, cyc, e[48:17]);
      end
    end else if (have && int'(e[48:17]) < cyc) begin
      if (sel) void'(exp_q3.pop_front());
      else     void'(exp_q1.pop_front());
      check({pref, "_rv_missing"}, 0, 1);
    end
  endtask

  always @(negedge clk) begin
    check("excl", {30'd0, gnt_a_1 & gnt_b_1, mem_we_1 & mem_re_1}, 0);
    ret_mon(1'b0, "lat1", rvalid_a_1, rvalid_b_1, rdata_a_1, rdata_b_1);
    ret_mon(1'b1, "lat3", rvalid_a_3, rvalid_b_3, rdata_a_3, rdata_b_3);
  end

  // ---------------- driver tasks ----------------
  bit alt_on    = 1'b0;
  bit alt_first = 1'b0;
  bit alt_prev_id;
  int alt_prev_cyc;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One request from requester id (0=A, 1=B); returns the grant cycle.
  task automatic access(input bit id, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input bit want_ret, output int gcyc);
    int   waited;
    logic g, other;
    waited = 0;
    gcyc   = -1;
    if (!id) begin req_a = 1'b1; wr_a = wr; addr_a = addr; wdata_a = data; end
    else     begin req_b = 1'b1; wr_b = wr; addr_b = addr; wdata_b = data; end
    do begin
      tick(1);
      waited++;
      g = id ? gnt_b_1 : gnt_a_1;
    end while (!g && waited < 12);
    if (!id) req_a = 1'b0;
    else     req_b = 1'b0;
    if (!g) begin
      check("gnt_timeout", 0, 1);
      return;
    end
    gcyc  = cyc;
    other = id ? gnt_a_1 : gnt_b_1;
    check("gnt_excl", {31'd0, other}, 0);
    if (wr) begin
      check("wr_cmd", {30'd0, mem_we_1, mem_re_1}, 2);
      check("wr_addr", {29'd0, mem_wr_addr_1}, {29'd0, addr});
      check("wr_data", {16'd0, mem_data_in_1}, {16'd0, data});
      shadow[addr] = data;
    end else begin
      check("rd_cmd", {30'd0, mem_we_1, mem_re_1}, 1);
      check("rd_addr", {29'd0, mem_rd_addr_1}, {29'd0, addr});
      if (want_ret) begin
        exp_q1.push_back({32'(cyc + 1 + LAT1), id, shadow[addr]});
        exp_q3.push_back({32'(cyc + 1 + LAT3), id, shadow[addr]});
      end
    end
    if (alt_on) begin
      if (alt_first) begin
        check("alt_first_id", {31'd0, id}, 1);
      end else begin
        check("alt_id", {31'd0, id}, {31'd0, ~alt_prev_id});
        check("alt_cycle", cyc, alt_prev_cyc + 1);
      end
      alt_first    = 1'b0;
      alt_prev_id  = id;
      alt_prev_cyc = cyc;
    end
  endtask

  // ---------------- main sequence ----------------
  int g, prev_g, ga, gb, t0;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset held for 3 cycles with requests toggling.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      req_a = (i % 2 == 0);
      req_b = (i % 2 == 1);
      check("rst_ctl1", {20'd0, gnt_a_1, gnt_b_1, rvalid_a_1, rvalid_b_1, mem_we_1, mem_re_1,
                         mem_wr_addr_1, mem_rd_addr_1}, 0);
      check("rst_data1", {rdata_a_1, rdata_b_1}, 0);
      check("rst_din1", {16'd0, mem_data_in_1}, 0);
      check("rst_ctl3", {26'd0, gnt_a_3, gnt_b_3, rvalid_a_3, rvalid_b_3, mem_we_3, mem_re_3}, 0);
    end

    // Release with both requesting: A wins, granted in the 2nd cycle.
    clr = 1'b0;
    req_a = 1'b1; wr_a = 1'b1; addr_a = 3'd0; wdata_a = 16'h0010;
    req_b = 1'b1; wr_b = 1'b1; addr_b = 3'd7; wdata_b = 16'h0017;
    check("rel_gnt0", {30'd0, gnt_a_1, gnt_b_1}, 0);
    tick(1);
    check("rel_gnt1", {30'd0, gnt_a_1, gnt_b_1}, 2);
    check("rel_wr_a", {13'd0, mem_we_1, mem_wr_addr_1, mem_data_in_1}, {13'd1, 3'd0, 16'h0010});
    shadow[0] = 16'h0010;
    req_a = 1'b0;
    tick(1);
    check("rel_gnt2", {30'd0, gnt_a_1, gnt_b_1}, 1);
    check("rel_wr_b", {13'd0, mem_we_1, mem_wr_addr_1, mem_data_in_1}, {13'd1, 3'd7, 16'h0017});
    shadow[7] = 16'h0017;
    req_b = 1'b0;
    tick(4);

    // Single writer: one access every 2 cycles.
    prev_g = 0;
    for (int i = 0; i < 8; i++) begin
      access(1'b0, 1'b1, 3'(i), 16'h0010 + 16'(i), 1'b0, g);
      if (i > 0) check("wr_gap", g - prev_g, 2);
      prev_g = g;
    end
    tick(1);
    check("hold_after_wr", {13'd0, mem_we_1, mem_wr_addr_1, mem_data_in_1}, {13'd0, 3'd7, 16'h0017});
    tick(3);

    // Single reader: data returns via the expected queues.
    for (int i = 0; i < 8; i++) begin
      access(1'b0, 1'b0, 3'(i), 16'h0000, 1'b1, g);
      if (i > 0) check("rd_gap", g - prev_g, 2);
      prev_g = g;
    end
    tick(6);

    // Interleaved reads from a tie; pointer last at A so B goes first.
    t0 = cyc;
    fork
      access(1'b0, 1'b0, 3'd1, 16'h0000, 1'b1, ga);
      access(1'b1, 1'b0, 3'd6, 16'h0000, 1'b1, gb);
    join
    check("il_gnt_b", gb, t0 + 1);
    check("il_gnt_a", ga, t0 + 2);
    tick(6);

    // Contention: A writes addr 2, B reads addr 2, both continuous.
    alt_on    = 1'b1;
    alt_first = 1'b1;
    fork
      for (int i = 0; i < 3; i++) begin
        int ta;
        access(1'b0, 1'b1, 3'd2, 16'hAAAA, 1'b0, ta);
      end
      for (int j = 0; j < 3; j++) begin
        int tb;
        access(1'b1, 1'b0, 3'd2, 16'h0000, 1'b1, tb);
      end
    join
    alt_on = 1'b0;
    tick(6);

    // Reset the cycle after a read grant: that read must never return.
    access(1'b0, 1'b0, 3'd5, 16'h0000, 1'b0, g);
    tick(1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("midrst_ctl", {26'd0, gnt_a_1, gnt_b_1, rvalid_a_1, rvalid_b_1, mem_we_1, mem_re_1}, 0);
    check("midrst_rdata", {16'd0, rdata_a_1}, 0);
    t0 = cyc;
    fork
      access(1'b0, 1'b0, 3'd5, 16'h0000, 1'b1, ga);
      access(1'b1, 1'b0, 3'd3, 16'h0000, 1'b1, gb);
    join
    check("post_rst_gnt_a", ga, t0 + 1);
    check("post_rst_gnt_b", gb, t0 + 2);
    tick(10);

    check("q1_empty", exp_q1.size(), 0);
    check("q3_empty", exp_q3.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
